// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: a fetch (read-only) port and a data (read/write) port share one
// single-cycle memory. Every access is IDLE -> ACC -> IDLE, with the ack issued as ACC ends.
module mem_arbiter #(
  parameter int unsigned PRIO_MODE    = 0,  // 0: round-robin, 1: data port has priority
  parameter int unsigned STARVE_LIMIT = 4   // data wins allowed while fetch waits (1..15)
) (
  input  logic        clock,
  input  logic        reset_n,
  // Fetch port
  input  logic        f_req,
  input  logic [15:0] f_addr,
  output logic        f_ack,
  output logic [15:0] f_rdata,
  // Data port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [15:0] d_rdata,
  // Memory side
  output logic [15:0] m_addr,
  output logic [15:0] m_wdata,
  output logic        m_re,
  output logic        m_we,
  input  logic [15:0] m_rdata,
  output logic        busy
);

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  typedef enum logic {StIdle, StAcc} state_e;

  state_e      state_q, state_d;
  logic        acc_data_q, acc_data_d;  // port owning the access in flight (1 = data)
  logic        acc_we_q, acc_we_d;
  logic [15:0] m_addr_q, m_addr_d;
  logic [15:0] m_wdata_q, m_wdata_d;
  logic [15:0] f_rdata_q, f_rdata_d;
  logic [15:0] d_rdata_q, d_rdata_d;
  logic        f_ack_q, f_ack_d;
  logic        d_ack_q, d_ack_d;
  logic        d_err_q, d_err_d;
  logic        last_data_q, last_data_d;
  logic [3:0]  starve_q, starve_d;

  logic f_elig, d_elig, grant_f, grant_d, d_reject;

  // Arbitration: a port being acked this cycle still shows its old request, so it is masked.
  always_comb begin
    f_elig   = f_req & ~f_ack_q;
    d_elig   = d_req & ~d_ack_q;
    grant_f  = 1'b0;
    grant_d  = 1'b0;
    d_reject = d_we & d_addr[0];
    if (state_q == StIdle) begin
      if (f_elig && d_elig) begin
        if (PRIO_MODE == 0) begin
          grant_f = last_data_q;
        end else begin
          grant_f = (starve_q == Limit);
        end
        grant_d = ~grant_f;
      end else begin
        grant_f = f_elig;
        grant_d = d_elig;
      end
    end
  end

  // Next-state: complete the access in flight, then load the new winner.
  always_comb begin
    state_d     = StIdle;
    acc_data_d  = acc_data_q;
    acc_we_d    = acc_we_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    f_rdata_d   = f_rdata_q;
    d_rdata_d   = d_rdata_q;
    f_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    d_err_d     = 1'b0;
    last_data_d = last_data_q;
    starve_d    = starve_q;

    if (state_q == StAcc) begin
      if (acc_data_q) begin
        d_ack_d = 1'b1;
        if (!acc_we_q) begin
          d_rdata_d = m_rdata;
        end
      end else begin
        f_ack_d   = 1'b1;
        f_rdata_d = m_rdata;
      end
    end

    if (grant_f) begin
      state_d     = StAcc;
      acc_data_d  = 1'b0;
      acc_we_d    = 1'b0;
      m_addr_d    = f_addr;
      last_data_d = 1'b0;
      starve_d    = 4'd0;
    end

    if (grant_d) begin
      last_data_d = 1'b1;
      if (f_req && (starve_q != Limit)) begin
        starve_d = starve_q + 4'd1;
      end
      if (d_reject) begin
        // Misaligned write: answered with an error, memory is never touched.
        d_ack_d = 1'b1;
        d_err_d = 1'b1;
      end else begin
        state_d    = StAcc;
        acc_data_d = 1'b1;
        acc_we_d   = d_we;
        m_addr_d   = d_addr;
        m_wdata_d  = d_wdata;
      end
    end
  end

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      acc_data_q  <= 1'b0;
      acc_we_q    <= 1'b0;
      m_addr_q    <= 16'h0000;
      m_wdata_q   <= 16'h0000;
      f_rdata_q   <= 16'h0000;
      d_rdata_q   <= 16'h0000;
      f_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      last_data_q <= 1'b1;
      starve_q    <= 4'd0;
    end else begin
      state_q     <= state_d;
      acc_data_q  <= acc_data_d;
      acc_we_q    <= acc_we_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      f_rdata_q   <= f_rdata_d;
      d_rdata_q   <= d_rdata_d;
      f_ack_q     <= f_ack_d;
      d_ack_q     <= d_ack_d;
      d_err_q     <= d_err_d;
      last_data_q <= last_data_d;
      starve_q    <= starve_d;
    end
  end

  assign busy    = (state_q == StAcc);
  assign m_re    = busy & ~acc_we_q;
  assign m_we    = busy & acc_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign f_ack   = f_ack_q;
  assign f_rdata = f_rdata_q;
  assign d_ack   = d_ack_q;
  assign d_err   = d_err_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 round-robin with a writable memory, instance 1 data-priority
// with a read-only address-derived memory. A transaction-level model predicts every output.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        fr [2];
  logic        dr [2];
  logic        dwe[2];
  logic [15:0] fa [2];
  logic [15:0] da [2];
  logic [15:0] dwd[2];

  logic        o_fack[2], o_dack[2], o_derr[2], o_re[2], o_we[2], o_busy[2];
  logic [15:0] o_frd[2], o_drd[2], o_ma[2], o_mwd[2], mrd[2];

  logic [15:0] mem [65536];
  assign mrd[0] = mem[o_ma[0]];
  assign mrd[1] = o_ma[1] ^ 16'hA5A5;

  mem_arbiter #(.PRIO_MODE(0), .STARVE_LIMIT(4)) u_rr (
    .clock(clk), .reset_n(reset_n),
    .f_req(fr[0]), .f_addr(fa[0]), .f_ack(o_fack[0]), .f_rdata(o_frd[0]),
    .d_req(dr[0]), .d_we(dwe[0]), .d_addr(da[0]), .d_wdata(dwd[0]),
    .d_ack(o_dack[0]), .d_err(o_derr[0]), .d_rdata(o_drd[0]),
    .m_addr(o_ma[0]), .m_wdata(o_mwd[0]), .m_re(o_re[0]), .m_we(o_we[0]),
    .m_rdata(mrd[0]), .busy(o_busy[0])
  );

  mem_arbiter #(.PRIO_MODE(1), .STARVE_LIMIT(4)) u_pr (
    .clock(clk), .reset_n(reset_n),
    .f_req(fr[1]), .f_addr(fa[1]), .f_ack(o_fack[1]), .f_rdata(o_frd[1]),
    .d_req(dr[1]), .d_we(dwe[1]), .d_addr(da[1]), .d_wdata(dwd[1]),
    .d_ack(o_dack[1]), .d_err(o_derr[1]), .d_rdata(o_drd[1]),
    .m_addr(o_ma[1]), .m_wdata(o_mwd[1]), .m_re(o_re[1]), .m_we(o_we[1]),
    .m_rdata(mrd[1]), .busy(o_busy[1])
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // ---------------- model ----------------
  bit          s_busy[2], s_port[2], s_we[2], s_fack[2], s_dack[2], s_derr[2], s_last_d[2];
  int          s_starve[2];
  logic [15:0] s_addr[2], s_wd[2], s_frd[2], s_drd[2];
  logic [15:0] mmem [65536];

  function automatic logic [15:0] rd_word(input int k, input logic [15:0] a);
    return (k == 0) ? mmem[a] : (a ^ 16'hA5A5);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      s_busy[k] = 0; s_port[k] = 0; s_we[k] = 0; s_fack[k] = 0; s_dack[k] = 0;
      s_derr[k] = 0; s_last_d[k] = 1; s_starve[k] = 0;
      s_addr[k] = 16'h0; s_wd[k] = 16'h0; s_frd[k] = 16'h0; s_drd[k] = 16'h0;
    end
  endtask

  // One clock of transactions: finish the pending access, then pick the next winner.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit was_busy, fe, de, gf, gd;
      was_busy = s_busy[k];
      fe = fr[k] && !s_fack[k];
      de = dr[k] && !s_dack[k];
      s_fack[k] = was_busy && !s_port[k];
      s_dack[k] = was_busy && s_port[k];
      s_derr[k] = 0;
      if (was_busy) begin
        if (s_we[k]) begin
          if (k == 0) mmem[s_addr[k]] = s_wd[k];
        end else if (s_port[k]) s_drd[k] = rd_word(k, s_addr[k]);
        else s_frd[k] = rd_word(k, s_addr[k]);
      end
      s_busy[k] = 0;
      gf = 0; gd = 0;
      if (!was_busy) begin
        if (fe && de) begin
          gf = (k == 0) ? s_last_d[k] : (s_starve[k] == 4);
          gd = !gf;
        end else begin
          gf = fe; gd = de;
        end
      end
      if (gf) begin
        s_starve[k] = 0; s_last_d[k] = 0;
        s_busy[k] = 1; s_port[k] = 0; s_we[k] = 0; s_addr[k] = fa[k];
      end
      if (gd) begin
        if (fr[k] && s_starve[k] < 4) s_starve[k]++;
        s_last_d[k] = 1;
        if (dwe[k] && da[k][0]) begin
          s_dack[k] = 1; s_derr[k] = 1;
        end else begin
          s_busy[k] = 1; s_port[k] = 1; s_we[k] = dwe[k]; s_addr[k] = da[k]; s_wd[k] = dwd[k];
        end
      end
    end
  endtask

  task automatic compare();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("busy%0d", k),   64'(o_busy[k]), 64'(s_busy[k]));
      chk($sformatf("m_re%0d", k),   64'(o_re[k]),   64'(s_busy[k] && !s_we[k]));
      chk($sformatf("m_we%0d", k),   64'(o_we[k]),   64'(s_busy[k] && s_we[k]));
      chk($sformatf("m_addr%0d", k), 64'(o_ma[k]),   64'(s_addr[k]));
      chk($sformatf("m_wd%0d", k),   64'(o_mwd[k]),  64'(s_wd[k]));
      chk($sformatf("f_ack%0d", k),  64'(o_fack[k]), 64'(s_fack[k]));
      chk($sformatf("d_ack%0d", k),  64'(o_dack[k]), 64'(s_dack[k]));
      chk($sformatf("d_err%0d", k),  64'(o_derr[k]), 64'(s_derr[k]));
      chk($sformatf("f_rd%0d", k),   64'(o_frd[k]),  64'(s_frd[k]));
      chk($sformatf("d_rd%0d", k),   64'(o_drd[k]),  64'(s_drd[k]));
    end
  endtask

  // Memory environment plus per-cycle model comparison.
  bit          pw_valid;
  logic [15:0] pw_a, pw_d;
  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]  = 16'(i) ^ 16'h5A5A;
      mmem[i] = 16'(i) ^ 16'h5A5A;
    end
    mem[16'h0010]  = 16'hBEEF;
    mmem[16'h0010] = 16'hBEEF;
    pw_valid = 0;
    model_reset();
    forever begin
      @(posedge clk);
      if (pw_valid && reset_n) mem[pw_a] = pw_d;
      pw_valid = 0;
      if (!reset_n) model_reset();
      else model_step();
      @(negedge clk);
      pw_valid = o_we[0]; pw_a = o_ma[0]; pw_d = o_mwd[0];
      if (!reset_n) model_reset();
      compare();
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  logic [63:0] glog;
  bit          found;

  initial begin
    reset_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      fr[k] = 0; dr[k] = 0; dwe[k] = 0; fa[k] = 16'h0; da[k] = 16'h0; dwd[k] = 16'h0;
    end
    cyc(1);
    chk("rst_busy",   64'(o_busy[0]), 64'd0);
    chk("rst_m_we",   64'(o_we[0]),   64'd0);
    chk("rst_m_addr", 64'(o_ma[0]),   64'd0);
    chk("rst_f_rd",   64'(o_frd[0]),  64'd0);
    chk("rst_d_rd",   64'(o_drd[0]),  64'd0);
    reset_n = 1'b1;
    cyc(1);

    // Fetch read of 0x0010
    fr[0] = 1; fa[0] = 16'h0010;
    cyc(1);
    chk("fetch_m_re", 64'(o_re[0]),   64'd1);
    chk("fetch_early_ack", 64'(o_fack[0]), 64'd0);
    cyc(1);
    chk("fetch_ack",  64'(o_fack[0]), 64'd1);
    chk("fetch_data", 64'(o_frd[0]),  64'hBEEF);
    fr[0] = 0;
    cyc(1);
    chk("fetch_ack_pulse", 64'(o_fack[0]), 64'd0);
    chk("fetch_data_hold", 64'(o_frd[0]),  64'hBEEF);

    // Aligned write then read back
    dr[0] = 1; dwe[0] = 1; da[0] = 16'h0020; dwd[0] = 16'h1234;
    cyc(1);
    chk("wr_m_we",    64'(o_we[0]),  64'd1);
    chk("wr_m_addr",  64'(o_ma[0]),  64'h0020);
    chk("wr_m_wdata", 64'(o_mwd[0]), 64'h1234);
    cyc(1);
    chk("wr_ack", 64'(o_dack[0]), 64'd1);
    chk("wr_err", 64'(o_derr[0]), 64'd0);
    dr[0] = 0;
    cyc(1);
    chk("wr_mem", 64'(mem[16'h0020]), 64'h1234);
    dr[0] = 1; dwe[0] = 0;
    cyc(1);
    chk("rd_m_re", 64'(o_re[0]), 64'd1);
    cyc(1);
    chk("rd_ack",  64'(o_dack[0]), 64'd1);
    chk("rd_data", 64'(o_drd[0]),  64'h1234);
    chk("rd_err",  64'(o_derr[0]), 64'd0);
    dr[0] = 0;
    cyc(1);

    // Misaligned write is rejected
    dr[0] = 1; dwe[0] = 1; da[0] = 16'h0021; dwd[0] = 16'hFFFF;
    cyc(1);
    chk("bad_ack",  64'(o_dack[0]), 64'd1);
    chk("bad_err",  64'(o_derr[0]), 64'd1);
    chk("bad_m_we", 64'(o_we[0]),   64'd0);
    chk("bad_busy", 64'(o_busy[0]), 64'd0);
    dr[0] = 0; dwe[0] = 0;
    cyc(1);
    chk("bad_err_clear", 64'(o_derr[0]), 64'd0);
    chk("bad_mem20", 64'(mem[16'h0020]), 64'h1234);
    chk("bad_mem21", 64'(mem[16'h0021]), 64'h5A7B);

    // Round-robin with both ports held, from reset
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    fr[0] = 1; fa[0] = 16'h0030; dr[0] = 1; dwe[0] = 0; da[0] = 16'h0040;
    glog = 64'h0;
    repeat (8) begin
      cyc(1);
      if (o_fack[0]) glog = {glog[55:0], 8'h46};
      if (o_dack[0]) glog = {glog[55:0], 8'h44};
    end
    chk("rr_alternate", glog, 64'h46444644);
    chk("rr_f_data", 64'(o_frd[0]), 64'h5A6A);
    chk("rr_d_data", 64'(o_drd[0]), 64'h5A1A);
    fr[0] = 0; dr[0] = 0;
    cyc(3);

    // Data priority: fetch loses four conflicts (withdrawing each time), then wins the fifth
    glog = 64'h0;
    for (int r = 0; r < 5; r++) begin
      fr[1] = 1; fa[1] = 16'h0050; dr[1] = 1; dwe[1] = 0; da[1] = 16'h0060 + 16'(r);
      for (int s = 0; s < 4; s++) begin
        cyc(1);
        if (o_fack[1]) begin glog = {glog[55:0], 8'h46}; fr[1] = 0; end
        if (o_dack[1]) begin glog = {glog[55:0], 8'h44}; dr[1] = 0; end
        if (s == 0 && r < 4) fr[1] = 0;
      end
    end
    chk("prio_starve", glog, 64'h444444444644);
    chk("prio_f_data", 64'(o_frd[1]), 64'h0050 ^ 64'hA5A5);
    chk("prio_d_data", 64'(o_drd[1]), 64'h0064 ^ 64'hA5A5);

    // Reset in the middle of a write access
    dr[0] = 1; dwe[0] = 1; da[0] = 16'h0022; dwd[0] = 16'h7777;
    cyc(1);
    chk("abort_m_we_before", 64'(o_we[0]), 64'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_m_we",   64'(o_we[0]),   64'd0);
    chk("abort_busy",   64'(o_busy[0]), 64'd0);
    chk("abort_m_addr", 64'(o_ma[0]),   64'd0);
    chk("abort_wdata",  64'(o_mwd[0]),  64'd0);
    chk("abort_d_ack",  64'(o_dack[0]), 64'd0);
    cyc(1);
    chk("abort_nowrite", 64'(mem[16'h0022]), 64'h5A78);
    reset_n = 1'b1;
    found = 0;
    for (int i = 0; i < 6 && !found; i++) begin
      cyc(1);
      if (o_dack[0]) found = 1;
    end
    chk("reissue_ack", 64'(found), 64'd1);
    dr[0] = 0; dwe[0] = 0;
    cyc(1);
    chk("reissue_mem", 64'(mem[16'h0022]), 64'h7777);
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
